// File: rtl/cache_refill_unit_pkg.sv
// Shared state encoding, default geometry and address-width helper for the refill path.
// The cache memory and control unit import the same package so their state views agree.
package cache_refill_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_e;

  localparam int DEF_TAG_SIZE       = 19;
  localparam int DEF_BLOCK_SIZE     = 8;
  localparam int DEF_WORD_SIZE      = 8;
  localparam int DEF_NUMBER_OF_SETS = 128;

  function automatic int mem_addr_width(input int tag_size, input int number_of_sets,
                                        input int block_size);
    return tag_size + $clog2(number_of_sets) + $clog2(block_size);
  endfunction

endpackage

// File: rtl/cache_refill_unit_line_buffer.sv
// Line assembly buffer: BLOCK_SIZE words written individually by offset, read as one flat line.
module cache_refill_unit_line_buffer #(
  parameter  int BLOCK_SIZE  = 8,
  parameter  int WORD_SIZE   = 8,
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            wr_en_i,
  input  logic [OFFSET_BITS-1:0]          wr_offset_i,
  input  logic [WORD_SIZE-1:0]            wr_data_i,
  output logic [BLOCK_SIZE*WORD_SIZE-1:0] line_o
);

  generate
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_word
      logic [WORD_SIZE-1:0] word_q;

      always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
          word_q <= '0;
        end else if (wr_en_i && (wr_offset_i == OFFSET_BITS'(gi))) begin
          word_q <= wr_data_i;
        end
      end

      assign line_o[gi*WORD_SIZE +: WORD_SIZE] = word_q;
    end
  endgenerate

endmodule

// File: rtl/cache_refill_unit.sv
// Miss handler: writes back a dirty victim, then refills the line critical-word-first,
// forwarding the critical word early and handing the assembled line to the cache memory.
module cache_refill_unit
  import cache_refill_unit_pkg::*;
#(
  parameter  int TAG_SIZE       = DEF_TAG_SIZE,
  parameter  int BLOCK_SIZE     = DEF_BLOCK_SIZE,
  parameter  int WORD_SIZE      = DEF_WORD_SIZE,
  parameter  int NUMBER_OF_SETS = DEF_NUMBER_OF_SETS,
  localparam int INDEX_BITS     = $clog2(NUMBER_OF_SETS),
  localparam int OFFSET_BITS    = $clog2(BLOCK_SIZE),
  localparam int MEM_ADDR_W     = mem_addr_width(TAG_SIZE, NUMBER_OF_SETS, BLOCK_SIZE),
  localparam int LINE_W         = BLOCK_SIZE * WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   miss_req,
  input  logic [TAG_SIZE-1:0]    miss_tag,
  input  logic [INDEX_BITS-1:0]  miss_index,
  input  logic [OFFSET_BITS-1:0] miss_offset,
  input  logic                   victim_dirty,
  input  logic [TAG_SIZE-1:0]    victim_tag,
  input  logic [LINE_W-1:0]      victim_data,
  output logic                   busy,
  output logic                   crit_valid,
  output logic [WORD_SIZE-1:0]   crit_data,
  output logic                   fill_valid,
  output logic [TAG_SIZE-1:0]    fill_tag,
  output logic [INDEX_BITS-1:0]  fill_index,
  output logic [LINE_W-1:0]      fill_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_SIZE-1:0]   mem_rdata
);

  localparam logic [OFFSET_BITS-1:0] LAST_CNT = OFFSET_BITS'(BLOCK_SIZE - 1);

  refill_state_e          state_q;
  logic [OFFSET_BITS-1:0] cnt_q;
  logic [TAG_SIZE-1:0]    tag_q, vtag_q, fill_tag_q;
  logic [INDEX_BITS-1:0]  index_q, fill_index_q;
  logic [OFFSET_BITS-1:0] offset_q;
  logic [LINE_W-1:0]      vdata_q;
  logic                   crit_valid_q, fill_valid_q, mem_req_q, mem_we_q;
  logic [WORD_SIZE-1:0]   crit_data_q, mem_wdata_q;
  logic [MEM_ADDR_W-1:0]  mem_addr_q;

  logic                   xfer_d;
  logic [OFFSET_BITS-1:0] cnt_inc_d;
  logic [OFFSET_BITS-1:0] fill_off_d;
  logic [LINE_W-1:0]      line_d;

  // An ack only counts while a request is actually outstanding.
  assign xfer_d     = mem_ack && mem_req_q;
  assign cnt_inc_d  = cnt_q + OFFSET_BITS'(1);
  assign fill_off_d = offset_q + cnt_inc_d;

  cache_refill_unit_line_buffer #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_line_buffer (
    .clk        (clk),
    .rst_b      (rst_b),
    .wr_en_i    ((state_q == FILL) && xfer_d),
    .wr_offset_i(mem_addr_q[OFFSET_BITS-1:0]),
    .wr_data_i  (mem_rdata),
    .line_o     (line_d)
  );

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      vtag_q       <= '0;
      index_q      <= '0;
      offset_q     <= '0;
      vdata_q      <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      fill_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_req) begin
            tag_q     <= miss_tag;
            vtag_q    <= victim_tag;
            index_q   <= miss_index;
            offset_q  <= miss_offset;
            vdata_q   <= victim_data;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
            if (victim_dirty) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {victim_tag, miss_index, {OFFSET_BITS{1'b0}}};
              mem_wdata_q <= victim_data[WORD_SIZE-1:0];
            end else begin
              state_q     <= FILL;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {miss_tag, miss_index, miss_offset};
              mem_wdata_q <= '0;
            end
          end
        end
        WB: begin
          if (xfer_d) begin
            if (cnt_q == LAST_CNT) begin
              // mem_req stays high: the fill read is presented straight after the last write.
              state_q     <= FILL;
              cnt_q       <= '0;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_addr_q  <= {tag_q, index_q, offset_q};
            end else begin
              cnt_q       <= cnt_inc_d;
              mem_addr_q  <= {vtag_q, index_q, cnt_inc_d};
              mem_wdata_q <= vdata_q[cnt_inc_d*WORD_SIZE +: WORD_SIZE];
            end
          end
        end
        FILL: begin
          if (xfer_d) begin
            if (cnt_q == '0) begin
              crit_valid_q <= 1'b1;
              crit_data_q  <= mem_rdata;
            end
            if (cnt_q == LAST_CNT) begin
              state_q      <= DONE;
              cnt_q        <= '0;
              mem_req_q    <= 1'b0;
              mem_addr_q   <= '0;
              fill_valid_q <= 1'b1;
              fill_tag_q   <= tag_q;
              fill_index_q <= index_q;
            end else begin
              cnt_q      <= cnt_inc_d;
              mem_addr_q <= {tag_q, index_q, fill_off_d};
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          fill_tag_q   <= '0;
          fill_index_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign fill_valid = fill_valid_q;
  assign fill_tag   = fill_tag_q;
  assign fill_index = fill_index_q;
  // The buffer holds stale or partial words outside DONE, so only expose it with the pulse.
  assign fill_data  = fill_valid_q ? line_d : '0;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: table of misses plus hand sequences for
// busy-ignore, spurious ack and reset-during-writeback, checked through scoreboard queues.
module tb_cache_refill_unit;

  localparam int TAG_SIZE = 19, BLOCK_SIZE = 8, WORD_SIZE = 8, NUMBER_OF_SETS = 128;
  localparam int INDEX_BITS = 7, OFFSET_BITS = 3, MEM_ADDR_W = 29, LINE_W = 64;

  logic                   clk = 1'b0;
  logic                   rst_b = 1'b1;
  logic                   miss_req = 1'b0;
  logic [TAG_SIZE-1:0]    miss_tag = '0;
  logic [INDEX_BITS-1:0]  miss_index = '0;
  logic [OFFSET_BITS-1:0] miss_offset = '0;
  logic                   victim_dirty = 1'b0;
  logic [TAG_SIZE-1:0]    victim_tag = '0;
  logic [LINE_W-1:0]      victim_data = '0;
  logic                   busy, crit_valid, fill_valid, mem_req, mem_we;
  logic [WORD_SIZE-1:0]   crit_data, mem_wdata;
  logic [TAG_SIZE-1:0]    fill_tag;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [LINE_W-1:0]      fill_data;
  logic [MEM_ADDR_W-1:0]  mem_addr;
  logic                   mem_ack = 1'b0;
  logic [WORD_SIZE-1:0]   mem_rdata = '0;

  cache_refill_unit #(
    .TAG_SIZE(TAG_SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WORD_SIZE(WORD_SIZE),
    .NUMBER_OF_SETS(NUMBER_OF_SETS)
  ) dut (
    .clk(clk), .rst_b(rst_b), .miss_req(miss_req), .miss_tag(miss_tag),
    .miss_index(miss_index), .miss_offset(miss_offset), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data), .busy(busy),
    .crit_valid(crit_valid), .crit_data(crit_data), .fill_valid(fill_valid),
    .fill_tag(fill_tag), .fill_index(fill_index), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [WORD_SIZE-1:0]  wdata;
  } mem_txn_t;

  typedef struct {
    logic [TAG_SIZE-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [LINE_W-1:0]     data;
  } fill_txn_t;

  typedef struct {
    logic                   dirty;
    logic [TAG_SIZE-1:0]    tag;
    logic [INDEX_BITS-1:0]  index;
    logic [OFFSET_BITS-1:0] offset;
    logic [TAG_SIZE-1:0]    vtag;
    logic [LINE_W-1:0]      vdata;
    int                     stall;
    int                     exp_fill_lat;
    int                     exp_crit_lat;
  } vec_t;

  mem_txn_t             mem_q[$];
  fill_txn_t            fill_q[$];
  logic [WORD_SIZE-1:0] crit_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int stall_max = 0;
  logic force_ack = 1'b0;
  int fill_count = 0, crit_count = 0, fill_cyc = 0, crit_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_SIZE-1:0] mem_word(input logic [MEM_ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {3'b000, a[28:24]} ^ 8'h3C;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: decides acks mid-cycle and checks each transfer against the scoreboard.
  int wait_cnt = 0;
  logic waiting = 1'b0;
  logic [MEM_ADDR_W-1:0] held_addr = '0;
  logic held_we = 1'b0;
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst_b && mem_req) begin
      if (!waiting) begin
        waiting   = 1'b1;
        wait_cnt  = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
        held_addr = mem_addr;
        held_we   = mem_we;
      end else begin
        check("req_stable_addr", 64'(mem_addr), 64'(held_addr));
        check("req_stable_we", 64'(mem_we), 64'(held_we));
      end
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        waiting   = 1'b0;
        if (mem_q.size() == 0) begin
          check("mem_unexpected_txn", 64'(mem_addr), 64'(0));
        end else begin
          mem_txn_t e;
          e = mem_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end else begin
        wait_cnt--;
      end
    end else begin
      waiting = 1'b0;
      if (!rst_b) mem_ack = force_ack;
    end
  end

  always @(negedge clk) begin
    if (crit_valid) begin
      crit_count++;
      crit_cyc = cyc;
      if (crit_q.size() == 0) begin
        check("crit_unexpected", 64'(crit_data), 64'(0));
      end else begin
        logic [WORD_SIZE-1:0] ec;
        ec = crit_q.pop_front();
        check("crit_data", 64'(crit_data), 64'(ec));
      end
    end
    if (fill_valid) begin
      fill_count++;
      fill_cyc = cyc;
      if (fill_q.size() == 0) begin
        check("fill_unexpected", 64'(fill_tag), 64'(0));
      end else begin
        fill_txn_t ef;
        ef = fill_q.pop_front();
        check("fill_tag", 64'(fill_tag), 64'(ef.tag));
        check("fill_index", 64'(fill_index), 64'(ef.index));
        check("fill_data", fill_data, ef.data);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_crit_valid"}, 64'(crit_valid), 64'(0));
    check({tag, "_crit_data"}, 64'(crit_data), 64'(0));
    check({tag, "_fill_valid"}, 64'(fill_valid), 64'(0));
    check({tag, "_fill_tag"}, 64'(fill_tag), 64'(0));
    check({tag, "_fill_index"}, 64'(fill_index), 64'(0));
    check({tag, "_fill_data"}, fill_data, 64'(0));
    check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
    check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  // Drives one miss for a cycle and pushes every transfer and result it must produce.
  task automatic start_miss(input vec_t v, output int t0);
    fill_txn_t f;
    @(posedge clk); #1;
    t0 = cyc;
    miss_req = 1'b1; miss_tag = v.tag; miss_index = v.index; miss_offset = v.offset;
    victim_dirty = v.dirty; victim_tag = v.vtag; victim_data = v.vdata;
    if (v.dirty) begin
      for (int i = 0; i < BLOCK_SIZE; i++)
        mem_q.push_back('{1'b1, {v.vtag, v.index, 3'(i)}, v.vdata[i*WORD_SIZE +: WORD_SIZE]});
    end
    f.tag = v.tag; f.index = v.index; f.data = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      logic [OFFSET_BITS-1:0] off;
      logic [MEM_ADDR_W-1:0] a;
      off = v.offset + 3'(i);
      a = {v.tag, v.index, off};
      mem_q.push_back('{1'b0, a, 8'h00});
      f.data[off*WORD_SIZE +: WORD_SIZE] = mem_word(a);
    end
    crit_q.push_back(mem_word({v.tag, v.index, v.offset}));
    fill_q.push_back(f);
    @(posedge clk); #1;
    miss_req = 1'b0;
    check("busy_after_req", 64'(busy), 64'(1));
  endtask

  task automatic wait_fill(input int base_fills);
    int n = 0;
    while (fill_count == base_fills && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (fill_count == base_fills) check("fill_timeout", 64'(0), 64'(1));
    #1;
  endtask

  task automatic run_miss(input int id, input vec_t v);
    int t0, bf, bc;
    bf = fill_count; bc = crit_count;
    stall_max = v.stall;
    start_miss(v, t0);
    repeat (2) @(posedge clk);
    #1;
    check("fill_data_hidden", fill_data, 64'(0));
    wait_fill(bf);
    if (v.exp_fill_lat != 0) check("fill_latency", 64'(fill_cyc - t0), 64'(v.exp_fill_lat));
    if (v.exp_crit_lat != 0) check("crit_latency", 64'(crit_cyc - t0), 64'(v.exp_crit_lat));
    check("crit_pulses", 64'(crit_count - bc), 64'(1));
    check("busy_after_fill", 64'(busy), 64'(0));
    check("mem_q_drained", 64'(mem_q.size()), 64'(0));
    $display("txn %0d dirty=%0b tag=%h idx=%h off=%0d stall=%0d fill_lat=%0d", id, v.dirty,
             v.tag, v.index, v.offset, v.stall, fill_cyc - t0);
  endtask

  vec_t vecs[7];

  initial begin
    int t0, bf;
    vec_t h;
    vecs[0] = '{1'b0, 19'h12345, 7'h05, 3'd0, 19'h00000, 64'h0, 0, 9, 2};
    vecs[1] = '{1'b1, 19'h1F00F, 7'h05, 3'd0, 19'h00ABC, 64'h0706050403020100, 0, 17, 10};
    vecs[2] = '{1'b0, 19'h7FFFF, 7'h7F, 3'd6, 19'h00000, 64'h0, 0, 9, 2};
    vecs[3] = '{1'b0, 19'h00001, 7'h00, 3'd7, 19'h00000, 64'h0, 0, 9, 2};
    vecs[4] = '{1'b1, 19'h2A5A5, 7'h33, 3'd3, 19'h15A5A, 64'hDEADBEEF01234567, 3, 0, 0};
    vecs[5] = '{1'b0, 19'h0F0F0, 7'h40, 3'd5, 19'h00000, 64'h0, 3, 0, 0};
    vecs[6] = '{1'b1, 19'h3C3C3, 7'h7F, 3'd7, 19'h7FFFF, 64'hF0E1D2C3B4A59687, 0, 17, 10};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_b = 1'b0;

    for (int i = 0; i < 7; i++) run_miss(i, vecs[i]);

    // miss_req pulsed during FILL must not start a second refill.
    stall_max = 0;
    bf = fill_count;
    start_miss(vecs[0], t0);
    repeat (2) @(posedge clk);
    #1;
    miss_req = 1'b1; miss_tag = 19'h55555; victim_dirty = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0; victim_dirty = 1'b0;
    wait_fill(bf);
    repeat (4) @(posedge clk);
    #1;
    check("busy_ignore_fills", 64'(fill_count - bf), 64'(1));
    check("busy_ignore_idle", 64'(busy), 64'(0));
    check("busy_ignore_mem_req", 64'(mem_req), 64'(0));
    $display("txn busy-ignore fills=%0d", fill_count - bf);
    run_miss(7, vecs[2]);

    // Acks with no request outstanding must leave the unit idle.
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stray_ack_busy", 64'(busy), 64'(0));
    check("stray_ack_mem_req", 64'(mem_req), 64'(0));
    force_ack = 1'b0;
    $display("txn stray-ack busy=%0b", busy);

    // Reset while writing back word 3 abandons the transfer.
    h = vecs[1];
    start_miss(h, t0);
    repeat (3) @(posedge clk);
    #1;
    check("wb3_offset", 64'(mem_addr[2:0]), 64'(3));
    check("wb3_we", 64'(mem_we), 64'(1));
    rst_b = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    mem_q.delete(); crit_q.delete(); fill_q.delete();
    @(negedge clk);
    rst_b = 1'b0;
    $display("txn reset-during-wb busy=%0b", busy);
    run_miss(8, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
